// File: rtl/cla16_pipe_if.sv
// Operand/result handshake bundle for cla16_pipe; master is the traffic source/sink,
// slave is the adder itself.
interface cla16_pipe_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_carry;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_carry;
   logic             PG;
   logic             GG;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_a, in_b, in_carry, out_ready,
      input  in_ready, out_valid, out_sum, out_carry, PG, GG, out_count
   );

   modport slave (
      input  in_valid, in_a, in_b, in_carry, out_ready,
      output in_ready, out_valid, out_sum, out_carry, PG, GG, out_count
   );
endinterface

// File: rtl/cla16_pipe.sv
// Two-stage adder: 4-bit lookahead groups + second-level carry unit; 2-cycle latency.
// in_ready follows out_ready combinationally, so a full pipe still streams 1/cycle.
module cla16_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input logic         clk,
   input logic         rst,
   cla16_pipe_if.slave bus
);
   localparam int NG = WIDTH / 4;

   if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 16) begin : g_width_chk
      $error("cla16_pipe: WIDTH must be 4, 8, 12 or 16");
   end

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_cin_q, s1_cin_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic             out_carry_q, out_carry_d;
   logic             pg_q, pg_d;
   logic             gg_q, gg_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [WIDTH-1:0] p, g, sum;
   logic [NG-1:0]    grp_p, grp_g;
   logic [NG:0]      c;
   logic             bit_c;
   logic             blk_g;
   logic             handoff, out_load, accept;

   // Group PG/GG feed the second-level carries; bits inside a group use their group's c[i].
   always_comb begin
      p     = s1_a_q ^ s1_b_q;
      g     = s1_a_q & s1_b_q;
      sum   = '0;
      grp_p = '0;
      grp_g = '0;
      c     = '0;
      c[0]  = s1_cin_q;
      bit_c = 1'b0;
      blk_g = 1'b0;
      for (int i = 0; i < NG; i++) begin
         grp_p[i] = &p[4*i +: 4];
         grp_g[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | ((&p[4*i+2 +: 2]) & g[4*i+1])
                  | ((&p[4*i+1 +: 3]) & g[4*i]);
         c[i+1]   = grp_g[i] | (grp_p[i] & c[i]);
         blk_g    = grp_g[i] | (grp_p[i] & blk_g);
         bit_c    = c[i];
         for (int j = 0; j < 4; j++) begin
            sum[4*i+j] = p[4*i+j] ^ bit_c;
            bit_c      = g[4*i+j] | (p[4*i+j] & bit_c);
         end
      end
   end

   assign handoff      = out_valid_q & bus.out_ready;
   assign out_load     = s1_valid_q & (~out_valid_q | bus.out_ready);
   assign bus.in_ready = ~s1_valid_q | out_load;
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_cin_d    = s1_cin_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_carry_d = out_carry_q;
      pg_d        = pg_q;
      gg_d        = gg_q;
      count_d     = count_q + {{(CNT_W-1){1'b0}}, handoff};

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = bus.in_a;
         s1_b_d     = bus.in_b;
         s1_cin_d   = bus.in_carry;
      end else if (out_load) begin
         s1_valid_d = 1'b0;
      end

      // A stalled result stays put until the consumer takes it.
      if (out_load) begin
         out_valid_d = 1'b1;
         out_sum_d   = sum;
         out_carry_d = c[NG];
         pg_d        = &grp_p;
         gg_d        = blk_g;
      end else if (handoff) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_cin_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_carry_q <= 1'b0;
         pg_q        <= 1'b0;
         gg_q        <= 1'b0;
         count_q     <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_cin_q    <= s1_cin_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_carry_q <= out_carry_d;
         pg_q        <= pg_d;
         gg_q        <= gg_d;
         count_q     <= count_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_carry = out_carry_q;
   assign bus.PG        = pg_q;
   assign bus.GG        = gg_q;
   assign bus.out_count = count_q;
endmodule

// File: tb/tb_cla16_pipe.sv
// Bench for cla16_pipe: a 16-bit instance and a 4-bit/4-bit-counter instance share one
// driver; sel picks which one the stimulus and the observed outputs belong to.
module tb_cla16_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;

   logic        in_valid_t  = 1'b0;
   logic        in_carry_t  = 1'b0;
   logic        out_ready_t = 1'b0;
   logic [15:0] a_t = '0;
   logic [15:0] b_t = '0;

   int total = 0;
   int bad   = 0;
   int rdy_low_cycles = 0;

   logic [18:0] exp_q[$];
   int          acc_q[$];
   logic [15:0] stim_a[$];
   logic [15:0] stim_b[$];
   logic        stim_c[$];

   always #5 clk = ~clk;

   cla16_pipe_if #(.WIDTH(16), .CNT_W(16)) bus16 ();
   cla16_pipe_if #(.WIDTH(4),  .CNT_W(4))  bus4 ();

   cla16_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   cla16_pipe #(.WIDTH(4),  .CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

   assign bus16.in_valid  = in_valid_t & ~sel;
   assign bus16.in_a      = a_t;
   assign bus16.in_b      = b_t;
   assign bus16.in_carry  = in_carry_t;
   assign bus16.out_ready = out_ready_t & ~sel;
   assign bus4.in_valid   = in_valid_t & sel;
   assign bus4.in_a       = a_t[3:0];
   assign bus4.in_b       = b_t[3:0];
   assign bus4.in_carry   = in_carry_t;
   assign bus4.out_ready  = out_ready_t & sel;

   logic        o_in_ready, o_valid, o_carry, o_pg, o_gg;
   logic [15:0] o_sum, o_count;
   assign o_in_ready = sel ? bus4.in_ready  : bus16.in_ready;
   assign o_valid    = sel ? bus4.out_valid : bus16.out_valid;
   assign o_carry    = sel ? bus4.out_carry : bus16.out_carry;
   assign o_pg       = sel ? bus4.PG        : bus16.PG;
   assign o_gg       = sel ? bus4.GG        : bus16.GG;
   assign o_sum      = sel ? {12'h000, bus4.out_sum}   : bus16.out_sum;
   assign o_count    = sel ? {12'h000, bus4.out_count} : bus16.out_count;

   // Reference: plain arithmetic on the low w bits; returns {PG, GG, carry, sum}.
   function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic c, input int w);
      logic [16:0] mask, full, gsum;
      logic [15:0] x;
      mask = (17'h1 << w) - 17'h1;
      full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'h0, c};
      gsum = ({1'b0, a} & mask) + ({1'b0, b} & mask);
      x    = (a ^ b) | ~mask[15:0];
      return {&x, gsum[w], full[w], full[15:0] & mask[15:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic clear_stim();
      stim_a.delete();
      stim_b.delete();
      stim_c.delete();
   endtask

   // rmode: 0 = out_ready always high, 1 = random, 2 = low for cycles 4..8
   task automatic stream(input string name, input int rmode, input int vpct, input int budget);
      int          n;
      int          sent;
      int          got;
      int          cyc;
      int          ac;
      int          w;
      logic        pv, pr, exp_rdy;
      logic [18:0] pout, o, e;
      n = stim_a.size();
      sent = 0; got = 0; cyc = 0;
      pv = 1'b0; pr = 1'b0; pout = '0;
      w = sel ? 4 : 16;
      rdy_low_cycles = 0;
      exp_q.delete();
      acc_q.delete();
      while ((sent < n || got < n) && cyc < budget) begin
         in_valid_t = (sent < n) && ($urandom_range(99) < vpct);
         if (in_valid_t) begin
            a_t = stim_a[sent]; b_t = stim_b[sent]; in_carry_t = stim_c[sent];
         end else begin
            a_t = 16'($urandom); b_t = 16'($urandom); in_carry_t = 1'($urandom);
         end
         case (rmode)
            0:       out_ready_t = 1'b1;
            1:       out_ready_t = ($urandom_range(99) < 60);
            2:       out_ready_t = !(cyc >= 4 && cyc < 9);
            default: out_ready_t = 1'b1;
         endcase
         #1;
         o = {o_pg, o_gg, o_carry, o_sum};
         if (pv && !pr) begin
            total++;
            if (o_valid !== 1'b1 || o !== pout) begin
               bad++;
               $display("FAIL %s hold: got v=%b %h want v=1 %h", name, o_valid, o, pout);
            end
         end
         exp_rdy = (exp_q.size() < 2) || out_ready_t;
         total++;
         if (o_in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL %s in_ready cyc %0d: got %b want %b", name, cyc, o_in_ready, exp_rdy);
         end
         if (o_in_ready === 1'b0) rdy_low_cycles++;
         if (o_valid === 1'b1 && out_ready_t) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL %s spurious: got result %h want none", name, o);
            end else begin
               e  = exp_q.pop_front();
               ac = acc_q.pop_front();
               if (o !== e) begin
                  bad++;
                  $display("FAIL %s result %0d: got %h want %h", name, got, o, e);
               end
               if (rmode == 0) begin
                  total++;
                  if (cyc - ac != 2) begin
                     bad++;
                     $display("FAIL %s latency: got %0d want 2", name, cyc - ac);
                  end
               end
               got++;
            end
         end
         if (in_valid_t && o_in_ready === 1'b1) begin
            exp_q.push_back(model(a_t, b_t, in_carry_t, w));
            acc_q.push_back(cyc);
            sent++;
         end
         pv = o_valid; pr = out_ready_t; pout = o;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid_t  = 1'b0;
      out_ready_t = 1'b0;
      total++;
      if (sent != n || got != n) begin
         bad++;
         $display("FAIL %s completion: got sent=%0d recv=%0d want %0d", name, sent, got, n);
      end
   endtask

   task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic [15:0] es, input logic ec,
                           input logic epg, input logic egg);
      int w;
      w = 0;
      sel = 1'b0;
      a_t = a; b_t = b; in_carry_t = c;
      in_valid_t = 1'b1; out_ready_t = 1'b0;
      #1;
      total++;
      if (o_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s accept: got in_ready=%b want 1", name, o_in_ready);
      end
      step();
      in_valid_t = 1'b0;
      while (o_valid !== 1'b1 && w < 5) begin
         step();
         w++;
      end
      total++;
      if (w != 1) begin
         bad++;
         $display("FAIL %s latency: got %0d extra cycles want 1", name, w);
      end
      total++;
      if ({o_sum, o_carry, o_pg, o_gg} !== {es, ec, epg, egg}) begin
         bad++;
         $display("FAIL %s value: got sum=%h c=%b pg=%b gg=%b want sum=%h c=%b pg=%b gg=%b",
                  name, o_sum, o_carry, o_pg, o_gg, es, ec, epg, egg);
      end
      out_ready_t = 1'b1;
      step();
      out_ready_t = 1'b0;
   endtask

   task automatic test_reset();
      logic seen;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         total++;
         if ({o_valid, o_count, o_sum, o_carry, o_pg, o_gg, o_in_ready} !==
             {1'b0, 16'h0, 16'h0, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL reset_state sel=%0d: got v=%b cnt=%h sum=%h c/pg/gg=%b%b%b rdy=%b want 0s rdy=1",
                     s, o_valid, o_count, o_sum, o_carry, o_pg, o_gg, o_in_ready);
         end
      end
      sel = 1'b0;
      rst = 1'b0;
      step();
      clear_stim();
      for (int k = 0; k < 3; k++) begin
         stim_a.push_back(16'h1111 * 16'(k)); stim_b.push_back(16'h0F0F); stim_c.push_back(1'b1);
      end
      stream("pre_reset", 0, 100, 50);
      in_valid_t = 1'b1; a_t = 16'h1234; b_t = 16'h4321; in_carry_t = 1'b0;
      step();
      a_t = 16'hABCD;
      step();
      in_valid_t = 1'b0;
      total++;
      if (o_valid !== 1'b1 || o_count !== 16'd3) begin
         bad++;
         $display("FAIL reset_pre: got v=%b cnt=%0d want v=1 cnt=3", o_valid, o_count);
      end
      #3;
      rst = 1'b1;
      #1;
      total++;
      if (o_valid !== 1'b0 || o_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_async: got v=%b cnt=%0d want v=0 cnt=0", o_valid, o_count);
      end
      step();
      rst = 1'b0;
      out_ready_t = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (o_valid === 1'b1) seen = 1'b1;
      end
      out_ready_t = 1'b0;
      total++;
      if (seen !== 1'b0 || o_count !== 16'd0) begin
         bad++;
         $display("FAIL reset_discard: got emitted=%b cnt=%0d want 0 0", seen, o_count);
      end
   endtask

   task automatic test_ripple();
      directed("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic test_generate();
      directed("generate", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      total++;
      if (o_count !== 16'd2) begin
         bad++;
         $display("FAIL directed_count: got %0d want 2", o_count);
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      do_reset();
      clear_stim();
      for (int k = 0; k < 10; k++) begin
         stim_a.push_back(16'h0001 + 16'(k));
         stim_b.push_back(16'h0100 * 16'(k));
         stim_c.push_back(k[0]);
      end
      stream("backpressure", 2, 100, 100);
      total++;
      if (rdy_low_cycles < 4) begin
         bad++;
         $display("FAIL bp_in_ready: got %0d low cycles want >=4", rdy_low_cycles);
      end
      total++;
      if (o_count !== 16'd10) begin
         bad++;
         $display("FAIL bp_count: got %0d want 10", o_count);
      end
   endtask

   task automatic test_exhaustive4();
      sel = 1'b1;
      do_reset();
      clear_stim();
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int c = 0; c < 2; c++) begin
               stim_a.push_back(16'(a)); stim_b.push_back(16'(b)); stim_c.push_back(c[0]);
            end
      stream("exhaustive4", 0, 100, 600);
      total++;
      if (o_count !== 16'd0) begin
         bad++;
         $display("FAIL exh_count: got %0d want 0", o_count);
      end
   endtask

   task automatic test_count_wrap();
      sel = 1'b1;
      do_reset();
      clear_stim();
      for (int k = 0; k < 17; k++) begin
         stim_a.push_back(16'($urandom_range(15))); stim_b.push_back(16'($urandom_range(15)));
         stim_c.push_back(1'($urandom));
      end
      stream("wrap", 1, 80, 400);
      total++;
      if (o_count !== 16'd1) begin
         bad++;
         $display("FAIL wrap_count: got %0d want 1", o_count);
      end
   endtask

   task automatic test_back_to_back_random();
      sel = 1'b0;
      do_reset();
      clear_stim();
      for (int k = 0; k < 10000; k++) begin
         stim_a.push_back(16'($urandom)); stim_b.push_back(16'($urandom));
         stim_c.push_back(1'($urandom));
      end
      stream("random", 1, 70, 60000);
      total++;
      if (o_count !== 16'd10000) begin
         bad++;
         $display("FAIL random_count: got %0d want 10000", o_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      test_reset();
      test_ripple();
      test_generate();
      test_backpressure();
      test_exhaustive4();
      test_count_wrap();
      test_back_to_back_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
